// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
package alu_sched_pkg;
    localparam int OPW  = 4;
    localparam int CTLW = 2;
    localparam int RESW = 9;

    // Only multiply is long-running; every other opcode is add-class.
    localparam logic [CTLW-1:0] OP_ADD = 2'd0;
    localparam logic [CTLW-1:0] OP_MUL = 2'd2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    typedef struct packed {
        logic [OPW-1:0]  data1;
        logic [OPW-1:0]  data2;
        logic [CTLW-1:0] control;
    } alu_op_t;
endpackage

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module alu_rr_pick
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               any,
    output logic [ID_W-1:0]    winner
);
    logic [ID_W-1:0] idx;

    // Walk NUM_REQ slots starting just past ptr; the first hit wins.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + ID_W'(1);
            if (req[idx] && !any) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end
endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one multi-cycle ALU among NUM_REQ requesters with round-robin
// arbitration, a completion timeout and a tagged response channel.
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*OPW-1:0]  req_data1,
    input  logic [NUM_REQ*OPW-1:0]  req_data2,
    input  logic [NUM_REQ*CTLW-1:0] req_control,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [RESW-1:0]         rsp_result,
    output logic                    rsp_err,
    output logic                    alu_valid,
    output logic [OPW-1:0]          alu_data1,
    output logic [OPW-1:0]          alu_data2,
    output logic [CTLW-1:0]         alu_control,
    input  logic                    alu_ready,
    input  logic [RESW-1:0]         alu_result,
    output logic                    busy
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e                        state_q, state_d;
    logic [ID_W-1:0]               ptr_q, ptr_d;
    logic [ID_W-1:0]               id_q, id_d;
    alu_op_t                       op_q, op_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [RESW-1:0]               res_q, res_d;
    logic                          err_q, err_d;

    logic                          pick_any;
    logic [ID_W-1:0]               pick_idx;
    logic [NUM_REQ-1:0][OPW-1:0]   d1_a, d2_a;
    logic [NUM_REQ-1:0][CTLW-1:0]  ctl_a;

    assign d1_a  = req_data1;
    assign d2_a  = req_data2;
    assign ctl_a = req_control;

    alu_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req    (req_valid),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_idx)
    );

    assign alu_valid   = (state_q == ISSUE);
    assign alu_data1   = op_q.data1;
    assign alu_data2   = op_q.data2;
    assign alu_control = op_q.control;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_id      = id_q;
    assign rsp_result  = res_q;
    assign rsp_err     = err_q;
    assign busy        = (state_q != IDLE);

    // Next-state logic; grants are only ever raised from IDLE.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        err_d     = err_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    req_ready[pick_idx] = 1'b1;
                    ptr_d   = pick_idx;
                    id_d    = pick_idx;
                    op_d    = '{data1: d1_a[pick_idx], data2: d2_a[pick_idx],
                                control: ctl_a[pick_idx]};
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // A stalled ALU here is still finishing an abandoned op.
                if (alu_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (alu_ready) begin
                    res_d   = alu_result;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; pointer starts so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            id_q    <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a latency-programmable ALU stub.
module tb_alu_rr_scheduler;
    import alu_sched_pkg::*;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*OPW-1:0]  req_data1, req_data2;
    logic [NUM_REQ*CTLW-1:0] req_control;
    logic                    rsp_valid, rsp_ready, rsp_err;
    logic [ID_W-1:0]         rsp_id;
    logic [RESW-1:0]         rsp_result;
    logic                    alu_valid, alu_ready, busy;
    logic [OPW-1:0]          alu_data1, alu_data2;
    logic [CTLW-1:0]         alu_control;
    logic [RESW-1:0]         alu_result;

    int   checks = 0;
    int   errors = 0;
    int   lat_cfg = 1;
    int   n;
    logic ok;
    logic [7:0]      bcnt;
    logic [RESW-1:0] stub_res;

    always #5 clk = ~clk;

    alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data1(req_data1), .req_data2(req_data2), .req_control(req_control),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .alu_valid(alu_valid), .alu_data1(alu_data1), .alu_data2(alu_data2),
        .alu_control(alu_control), .alu_ready(alu_ready), .alu_result(alu_result),
        .busy(busy)
    );

    // ALU stub: ready low for lat_cfg cycles after each accepted op.
    assign alu_ready  = (bcnt == 8'd0);
    assign alu_result = stub_res;
    always @(posedge clk) begin
        if (reset) begin
            bcnt     <= 8'd0;
            stub_res <= '0;
        end else if (alu_valid && alu_ready) begin
            bcnt     <= 8'(lat_cfg);
            stub_res <= (alu_control == OP_MUL) ? 9'(alu_data1) * 9'(alu_data2)
                                                : 9'(alu_data1) + 9'(alu_data2);
        end else if (bcnt != 8'd0) begin
            bcnt <= bcnt - 8'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input int d1, input int d2, input int c);
        req_data1[4*i +: 4]   = 4'(d1);
        req_data2[4*i +: 4]   = 4'(d2);
        req_control[2*i +: 2] = 2'(c);
    endtask

    task automatic wait_rsp(input int maxc, output int cnt);
        cnt = 0;
        while (!rsp_valid && cnt < maxc) begin
            step();
            cnt++;
        end
        chk("rsp_arrives", 32'(rsp_valid), 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_alu_valid"}, 32'(alu_valid), 0);
        chk({tag, "_alu_data"}, 32'({alu_data1, alu_data2, alu_control}), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
        chk({tag, "_rsp_result"}, 32'(rsp_result), 0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_data1 = '0; req_data2 = '0;
        req_control = '0; rsp_ready = 1'b0;
        step(); step(); settle();
        chk_reset_vals("rst");
        reset = 1'b0;

        // Single add-class op from requester 2
        set_req(2, 5, 3, 0); req_valid = 4'b0100; settle();
        chk("t1_grant", 32'(req_ready), 4);
        step(); req_valid = '0; settle();
        chk("t1_busy", 32'(busy), 1);
        chk("t1_alu_valid", 32'(alu_valid), 1);
        chk("t1_alu_ops", 32'({alu_data1, alu_data2, alu_control}), 32'({4'd5, 4'd3, 2'd0}));
        wait_rsp(20, n);
        chk("t1_latency", 32'(n), 3);
        chk("t1_id", 32'(rsp_id), 2);
        chk("t1_result", 32'(rsp_result), 8);
        chk("t1_err", 32'(rsp_err), 0);
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0; settle();
        chk("t1_idle", 32'({rsp_valid, busy}), 0);

        // Multiply on requester 3 while requester 1 waits
        lat_cfg = 5;
        set_req(3, 5, 3, 2); set_req(1, 1, 1, 0); req_valid = 4'b1010; settle();
        chk("t2_grant", 32'(req_ready), 8);
        step(); req_valid = 4'b0010; settle();
        n = 0; ok = 1'b1;
        while (!rsp_valid && n < 30) begin
            if (!busy || req_ready != '0) ok = 1'b0;
            step(); n++;
        end
        chk("t2_latency", 32'(n), 7);
        chk("t2_busy_noready", 32'(ok), 1);
        chk("t2_id", 32'(rsp_id), 3);
        chk("t2_result", 32'(rsp_result), 15);
        chk("t2_err", 32'(rsp_err), 0);
        rsp_ready = 1'b1; settle();
        chk("t2_no_grant_in_resp", 32'(req_ready), 0);
        step(); rsp_ready = 1'b0; lat_cfg = 1; settle();
        chk("t2_next_grant", 32'(req_ready), 2);
        step(); req_valid = '0;
        wait_rsp(20, n);
        chk("t2b_id", 32'(rsp_id), 1);
        chk("t2b_result", 32'(rsp_result), 2);
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

        // Response backpressure
        set_req(2, 7, 9, 1); set_req(0, 2, 2, 3); req_valid = 4'b0101; settle();
        chk("t4_grant", 32'(req_ready), 4);
        step(); req_valid = 4'b0001;
        wait_rsp(20, n);
        chk("t4_result", 32'(rsp_result), 16);
        ok = 1'b1;
        repeat (6) begin
            step();
            if (!rsp_valid || rsp_id != 2'd2 || rsp_result != 9'd16 ||
                req_ready != '0 || alu_valid) ok = 1'b0;
        end
        chk("t4_stable", 32'(ok), 1);
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0; settle();
        chk("t4_next_grant", 32'(req_ready), 1);
        step(); req_valid = '0;
        wait_rsp(20, n);
        chk("t4b_id", 32'(rsp_id), 0);
        chk("t4b_result", 32'(rsp_result), 4);
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

        // ALU never completes: timeout, then next op stalls in ISSUE
        lat_cfg = 40;
        set_req(1, 3, 4, 0); req_valid = 4'b0010; settle();
        step(); req_valid = '0;
        wait_rsp(40, n);
        chk("t5_latency", 32'(n), 16);
        chk("t5_err", 32'(rsp_err), 1);
        chk("t5_result", 32'(rsp_result), 0);
        chk("t5_id", 32'(rsp_id), 1);
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
        lat_cfg = 1;
        set_req(2, 6, 6, 0); req_valid = 4'b0100; settle();
        step(); req_valid = '0; settle();
        ok = 1'b1;
        repeat (5) begin
            if (!alu_valid || alu_data1 != 4'd6 || alu_ready) ok = 1'b0;
            step();
        end
        chk("t5_issue_hold", 32'(ok), 1);
        wait_rsp(60, n);
        chk("t5b_err", 32'(rsp_err), 0);
        chk("t5b_result", 32'(rsp_result), 12);
        chk("t5b_id", 32'(rsp_id), 2);
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

        // Reset during WAIT of a multiply
        lat_cfg = 5;
        set_req(3, 5, 3, 2); req_valid = 4'b1000; settle();
        step(); req_valid = '0;
        step(); step(); settle();
        chk("t6_busy_before", 32'(busy), 1);
        reset = 1'b1; step(); reset = 1'b0; settle();
        chk_reset_vals("t6");
        ok = 1'b1;
        repeat (10) begin
            step();
            if (rsp_valid || busy) ok = 1'b0;
        end
        chk("t6_no_rsp", 32'(ok), 1);

        // Round-robin with all requesters continuously valid
        lat_cfg = 1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, i + 1, i + 10, 0);
        req_valid = 4'hF; rsp_ready = 1'b1; settle();
        for (int k = 0; k < 6; k++) begin
            chk("t3_grant", 32'(req_ready), 32'(1) << (k % 4));
            step(); settle();
            chk("t3_alu_data1", 32'(alu_data1), 32'(k % 4 + 1));
            chk("t3_alu_data2", 32'(alu_data2), 32'(k % 4 + 10));
            wait_rsp(20, n);
            chk("t3_id", 32'(rsp_id), 32'(k % 4));
            chk("t3_result", 32'(rsp_result), 32'(2 * (k % 4) + 11));
            step(); settle();
        end
        req_valid = '0; rsp_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
